// File: rtl/rob_module.sv
// -----------------------------------------------------------------------------
// rob_module
//   Circular reorder buffer for the Tomasulo core. Renamed ops from the
//   register-file stage are allocated at the tail, and the tail index is
//   exported so the regfile can rename the destination. Each allocated op is
//   dispatched to the reservation stations one cycle later with its operands
//   resolved as far as possible: from the regfile, from a same-edge FU
//   writeback, or from a completed ROB entry. FU writebacks mark entries
//   ready. Entries retire strictly in order, at most one per cycle, on the
//   commit bus.
//
// Ports
//   in_clk, in_rst                  clock, synchronous active-high reset
//   in_reg_*                        op presented by the regfile stage
//   in_fu_*                         FU writeback (entry index, value, flags)
//   out_next_rob_index              current tail (combinational)
//   out_full                        ROB holds ROB_SIZE entries (combinational)
//   out_overflow                    sticky: allocation attempted while full
//   out_rs_*                        registered dispatch to reservation stations
//   out_commit_*                    registered in-order retirement bus
// -----------------------------------------------------------------------------
module rob_module #(
    parameter int ROB_SIZE  = 16,
    parameter int IDX_W     = 4,
    parameter int GPR_IDX_W = 5,
    parameter int DATA_W    = 64
) (
    input  logic                 in_clk,
    input  logic                 in_rst,

    input  logic                 in_reg_done,
    input  logic [GPR_IDX_W-1:0] in_reg_dst,
    input  logic                 in_reg_set_nzcv,
    input  logic                 in_reg_src1_valid,
    input  logic [IDX_W-1:0]     in_reg_src1_rob_idx,
    input  logic [DATA_W-1:0]    in_reg_src1_value,
    input  logic                 in_reg_src2_valid,
    input  logic [IDX_W-1:0]     in_reg_src2_rob_idx,
    input  logic [DATA_W-1:0]    in_reg_src2_value,

    input  logic                 in_fu_done,
    input  logic [IDX_W-1:0]     in_fu_rob_idx,
    input  logic [DATA_W-1:0]    in_fu_value,
    input  logic [3:0]           in_fu_nzcv,

    output logic [IDX_W-1:0]     out_next_rob_index,
    output logic                 out_full,
    output logic                 out_overflow,

    output logic                 out_rs_done,
    output logic [IDX_W-1:0]     out_rs_dst_rob_idx,
    output logic                 out_rs_src1_valid,
    output logic [DATA_W-1:0]    out_rs_src1_value,
    output logic [IDX_W-1:0]     out_rs_src1_rob_idx,
    output logic                 out_rs_src2_valid,
    output logic [DATA_W-1:0]    out_rs_src2_value,
    output logic [IDX_W-1:0]     out_rs_src2_rob_idx,

    output logic                 out_commit_done,
    output logic [IDX_W-1:0]     out_commit_rob_index,
    output logic [GPR_IDX_W-1:0] out_commit_reg_index,
    output logic [DATA_W-1:0]    out_commit_value,
    output logic                 out_commit_set_nzcv,
    output logic [3:0]           out_commit_nzcv
);

    localparam logic [IDX_W:0] LP_SIZE = (IDX_W+1)'(ROB_SIZE);

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] val;
        logic [IDX_W-1:0]  idx;
    } src_t;

    // Per-entry state
    logic                 r_busy     [ROB_SIZE];
    logic                 r_ready    [ROB_SIZE];
    logic [GPR_IDX_W-1:0] r_dst      [ROB_SIZE];
    logic                 r_set_nzcv [ROB_SIZE];
    logic [DATA_W-1:0]    r_value    [ROB_SIZE];
    logic [3:0]           r_nzcv     [ROB_SIZE];

    // Queue pointers
    logic [IDX_W-1:0]     r_head;
    logic [IDX_W-1:0]     r_tail;
    logic [IDX_W:0]       r_count;

    logic                 w_alloc;
    logic                 w_commit;
    logic                 w_fu_wb;
    src_t                 w_src1;
    src_t                 w_src2;

    // Operand resolution, in priority order: architectural value, same-edge
    // FU bypass, completed ROB entry, otherwise keep waiting on the tag.
    function automatic src_t f_resolve(
        input logic              reg_valid,
        input logic [DATA_W-1:0] reg_value,
        input logic [IDX_W-1:0]  tag,
        input logic              fu_hit,
        input logic              ent_ready,
        input logic [DATA_W-1:0] ent_value
    );
        src_t s;
        s.idx = tag;
        if (reg_valid) begin
            s.vld = 1'b1;
            s.val = reg_value;
        end else if (fu_hit) begin
            s.vld = 1'b1;
            s.val = in_fu_value;
        end else if (ent_ready) begin
            s.vld = 1'b1;
            s.val = ent_value;
        end else begin
            s.vld = 1'b0;
            s.val = '0;
        end
        return s;
    endfunction

    assign out_next_rob_index = r_tail;
    assign out_full           = (r_count == LP_SIZE);

    // The full check uses pre-edge occupancy, so a commit in the same cycle
    // does not free a slot for a simultaneous allocation.
    assign w_alloc  = in_reg_done && !out_full;
    assign w_commit = (r_count != '0) && r_ready[r_head];
    assign w_fu_wb  = in_fu_done && r_busy[in_fu_rob_idx];

    assign w_src1 = f_resolve(in_reg_src1_valid, in_reg_src1_value, in_reg_src1_rob_idx,
                              in_fu_done && (in_fu_rob_idx == in_reg_src1_rob_idx),
                              r_busy[in_reg_src1_rob_idx] && r_ready[in_reg_src1_rob_idx],
                              r_value[in_reg_src1_rob_idx]);

    assign w_src2 = f_resolve(in_reg_src2_valid, in_reg_src2_value, in_reg_src2_rob_idx,
                              in_fu_done && (in_fu_rob_idx == in_reg_src2_rob_idx),
                              r_busy[in_reg_src2_rob_idx] && r_ready[in_reg_src2_rob_idx],
                              r_value[in_reg_src2_rob_idx]);

    // Entry array: writeback, allocate at tail, release at head.
    // Tail is never busy when an allocation is accepted and head is never the
    // tail while both allocate and commit happen, so the updates never collide
    // on a live entry.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                r_busy[i]  <= 1'b0;
                r_ready[i] <= 1'b0;
            end
        end else begin
            if (w_fu_wb) begin
                r_ready[in_fu_rob_idx] <= 1'b1;
                r_value[in_fu_rob_idx] <= in_fu_value;
                r_nzcv[in_fu_rob_idx]  <= in_fu_nzcv;
            end
            if (w_alloc) begin
                r_busy[r_tail]     <= 1'b1;
                r_ready[r_tail]    <= 1'b0;
                r_dst[r_tail]      <= in_reg_dst;
                r_set_nzcv[r_tail] <= in_reg_set_nzcv;
            end
            if (w_commit) begin
                r_busy[r_head]  <= 1'b0;
                r_ready[r_head] <= 1'b0;
            end
        end
    end

    // Head/tail/count; indices wrap naturally at IDX_W bits.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_commit) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_overflow <= 1'b0;
        end else if (in_reg_done && out_full) begin
            out_overflow <= 1'b1;
        end
    end

    // Dispatch stage: one-cycle registered copy of the accepted op.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_rs_done         <= 1'b0;
            out_rs_dst_rob_idx  <= '0;
            out_rs_src1_valid   <= 1'b0;
            out_rs_src1_value   <= '0;
            out_rs_src1_rob_idx <= '0;
            out_rs_src2_valid   <= 1'b0;
            out_rs_src2_value   <= '0;
            out_rs_src2_rob_idx <= '0;
        end else begin
            out_rs_done <= w_alloc;
            if (w_alloc) begin
                out_rs_dst_rob_idx  <= r_tail;
                out_rs_src1_valid   <= w_src1.vld;
                out_rs_src1_value   <= w_src1.val;
                out_rs_src1_rob_idx <= w_src1.idx;
                out_rs_src2_valid   <= w_src2.vld;
                out_rs_src2_value   <= w_src2.val;
                out_rs_src2_rob_idx <= w_src2.idx;
            end
        end
    end

    // Commit stage: retire the head entry using pre-edge state, so a
    // writeback at edge N can retire at edge N+1 at the earliest.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_commit_done      <= 1'b0;
            out_commit_rob_index <= '0;
            out_commit_reg_index <= '0;
            out_commit_value     <= '0;
            out_commit_set_nzcv  <= 1'b0;
            out_commit_nzcv      <= '0;
        end else begin
            out_commit_done <= w_commit;
            if (w_commit) begin
                out_commit_rob_index <= r_head;
                out_commit_reg_index <= r_dst[r_head];
                out_commit_value     <= r_value[r_head];
                out_commit_set_nzcv  <= r_set_nzcv[r_head];
                out_commit_nzcv      <= r_nzcv[r_head];
            end
        end
    end

endmodule

// File: tb/tb_rob_module.sv
module tb_rob_module;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        reg_done;
    logic [4:0]  reg_dst;
    logic        reg_setn;
    logic        s1_v, s2_v;
    logic [3:0]  s1_t, s2_t;
    logic [63:0] s1_x, s2_x;
    logic        fu_done;
    logic [3:0]  fu_idx;
    logic [63:0] fu_val;
    logic [3:0]  fu_nz;

    logic [3:0]  next_idx;
    logic        full, ovf;
    logic        rs_done;
    logic [3:0]  rs_dst;
    logic        rs1_v, rs2_v;
    logic [63:0] rs1_x, rs2_x;
    logic [3:0]  rs1_t, rs2_t;
    logic        c_done;
    logic [3:0]  c_rob;
    logic [4:0]  c_reg;
    logic [63:0] c_val;
    logic        c_setn;
    logic [3:0]  c_nz;

    rob_module dut (
        .in_clk(clk), .in_rst(rst),
        .in_reg_done(reg_done), .in_reg_dst(reg_dst), .in_reg_set_nzcv(reg_setn),
        .in_reg_src1_valid(s1_v), .in_reg_src1_rob_idx(s1_t), .in_reg_src1_value(s1_x),
        .in_reg_src2_valid(s2_v), .in_reg_src2_rob_idx(s2_t), .in_reg_src2_value(s2_x),
        .in_fu_done(fu_done), .in_fu_rob_idx(fu_idx), .in_fu_value(fu_val), .in_fu_nzcv(fu_nz),
        .out_next_rob_index(next_idx), .out_full(full), .out_overflow(ovf),
        .out_rs_done(rs_done), .out_rs_dst_rob_idx(rs_dst),
        .out_rs_src1_valid(rs1_v), .out_rs_src1_value(rs1_x), .out_rs_src1_rob_idx(rs1_t),
        .out_rs_src2_valid(rs2_v), .out_rs_src2_value(rs2_x), .out_rs_src2_rob_idx(rs2_t),
        .out_commit_done(c_done), .out_commit_rob_index(c_rob), .out_commit_reg_index(c_reg),
        .out_commit_value(c_val), .out_commit_set_nzcv(c_setn), .out_commit_nzcv(c_nz)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: in-flight entries kept as an ordered queue of indices,
    // plus per-index contents.
    bit          m_busy  [16];
    bit          m_ready [16];
    logic [4:0]  m_dst   [16];
    bit          m_setn  [16];
    logic [63:0] m_val   [16];
    logic [3:0]  m_nz    [16];
    int          m_order [$];
    int          m_tail;
    bit          m_ovf;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_busy[i]  = 0;
            m_ready[i] = 0;
        end
        m_order.delete();
        m_tail = 0;
        m_ovf  = 0;
    endtask

    task automatic resolve(input bit v, input int t, input logic [63:0] x,
                           input bit fd, input int fi, input logic [63:0] fv,
                           output bit ev, output logic [63:0] ex);
        if (v) begin
            ev = 1; ex = x;
        end else if (fd && fi == t) begin
            ev = 1; ex = fv;
        end else if (m_busy[t] && m_ready[t]) begin
            ev = 1; ex = m_val[t];
        end else begin
            ev = 0; ex = '0;
        end
    endtask

    task automatic cycle(input bit r, input bit rd, input logic [4:0] dst, input bit sn,
                         input bit v1, input int t1, input logic [63:0] x1,
                         input bit v2, input int t2, input logic [63:0] x2,
                         input bit fd, input int fi, input logic [63:0] fv, input logic [3:0] fn);
        bit          acc, cm, wb, ev1, ev2;
        int          ch, old_tail, sz;
        logic [63:0] ex1, ex2;
        logic [4:0]  e_dst;
        logic [63:0] e_val;
        bit          e_setn;
        logic [3:0]  e_nz;

        rst = r; reg_done = rd; reg_dst = dst; reg_setn = sn;
        s1_v = v1; s1_t = 4'(t1); s1_x = x1;
        s2_v = v2; s2_t = 4'(t2); s2_x = x2;
        fu_done = fd; fu_idx = 4'(fi); fu_val = fv; fu_nz = fn;
        #1;
        sz = m_order.size();
        check("next_rob_index", 64'(next_idx), 64'(m_tail));
        check("full", 64'(full), 64'(sz == 16));

        acc = rd && sz < 16;
        old_tail = m_tail;
        cm = sz > 0 && m_ready[m_order[0]];
        ch = cm ? m_order[0] : 0;
        e_dst = m_dst[ch]; e_val = m_val[ch]; e_setn = m_setn[ch]; e_nz = m_nz[ch];
        wb = fd && m_busy[fi];
        resolve(v1, t1, x1, fd, fi, fv, ev1, ex1);
        resolve(v2, t2, x2, fd, fi, fv, ev2, ex2);

        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
            check("rst_rs_done", 64'(rs_done), 0);
            check("rst_rs_dst", 64'(rs_dst), 0);
            check("rst_commit_done", 64'(c_done), 0);
            check("rst_commit_value", c_val, 0);
            check("rst_overflow", 64'(ovf), 0);
            return;
        end
        if (rd && sz == 16) m_ovf = 1;
        check("rs_done", 64'(rs_done), 64'(acc));
        if (acc) begin
            check("rs_dst_rob_idx", 64'(rs_dst), 64'(old_tail));
            check("rs_src1_valid", 64'(rs1_v), 64'(ev1));
            if (ev1) check("rs_src1_value", rs1_x, ex1);
            else     check("rs_src1_rob_idx", 64'(rs1_t), 64'(t1));
            check("rs_src2_valid", 64'(rs2_v), 64'(ev2));
            if (ev2) check("rs_src2_value", rs2_x, ex2);
            else     check("rs_src2_rob_idx", 64'(rs2_t), 64'(t2));
        end
        check("overflow", 64'(ovf), 64'(m_ovf));
        check("commit_done", 64'(c_done), 64'(cm));
        if (cm) begin
            check("commit_rob_index", 64'(c_rob), 64'(ch));
            check("commit_reg_index", 64'(c_reg), 64'(e_dst));
            check("commit_value", c_val, e_val);
            check("commit_set_nzcv", 64'(c_setn), 64'(e_setn));
            check("commit_nzcv", 64'(c_nz), 64'(e_nz));
        end

        if (wb) begin
            m_ready[fi] = 1; m_val[fi] = fv; m_nz[fi] = fn;
        end
        if (acc) begin
            m_busy[old_tail] = 1; m_ready[old_tail] = 0;
            m_dst[old_tail] = dst; m_setn[old_tail] = sn;
            m_order.push_back(old_tail);
            m_tail = (m_tail + 1) % 16;
        end
        if (cm) begin
            m_busy[ch] = 0; m_ready[ch] = 0;
            void'(m_order.pop_front());
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic alloc(input logic [4:0] dst);
        cycle(0, 1, dst, dst[0], 1, 0, 64'(dst) + 100, 0, 3, 0, 0, 0, 0, 0);
    endtask
    task automatic wback(input int idx, input logic [63:0] v);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, idx, v, 4'(idx));
    endtask

    initial begin
        model_reset();

        // Reset then idle
        do_reset();
        repeat (3) idle();
        check("idle_next_idx", 64'(next_idx), 0);

        // Single op: allocate, write back, commit
        alloc(5'd3);
        check("t2_rs_dst", 64'(rs_dst), 0);
        wback(0, 64'd42);
        idle();
        check("t2_commit_reg", 64'(c_reg), 3);
        check("t2_commit_val", c_val, 42);

        // Out-of-order writeback, in-order commit
        do_reset();
        alloc(5'd1);
        alloc(5'd2);
        wback(1, 64'd11);
        wback(0, 64'd10);
        check("t3_no_commit_yet", 64'(c_done), 0);
        idle();
        check("t3_first_commit", 64'(c_rob), 0);
        idle();
        check("t3_second_commit", 64'(c_rob), 1);

        // Fill, overflow, drain and wrap
        do_reset();
        for (int i = 0; i < 16; i++) alloc(5'(i));
        check("t4_full", 64'(full), 1);
        alloc(5'd20);
        check("t4_overflow", 64'(ovf), 1);
        check("t4_tail_held", 64'(next_idx), 0);
        for (int i = 0; i < 16; i++) wback(i, 64'(i * 3));
        repeat (3) idle();
        alloc(5'd7);
        check("t4_wrap_idx", 64'(rs_dst), 0);

        // Operand bypass and entry forwarding
        do_reset();
        alloc(5'd1);
        alloc(5'd2);
        alloc(5'd3);
        cycle(0, 1, 5'd4, 0, 0, 2, 0, 1, 0, 64'd9, 1, 2, 64'd7, 4'h5);
        check("t5_bypass_valid", 64'(rs1_v), 1);
        check("t5_bypass_value", rs1_x, 7);
        cycle(0, 1, 5'd5, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        check("t5_entry_value", rs1_x, 7);

        // Reset with live entries discards them
        do_reset();
        for (int i = 0; i < 5; i++) alloc(5'(i + 8));
        do_reset();
        for (int i = 0; i < 5; i++) wback(i, 64'(i + 1));
        repeat (3) idle();
        check("t6_no_commit", 64'(c_done), 0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit r, rd, v1, v2, fd;
            int fi, sz;
            r  = ($urandom_range(0, 299) == 0);
            rd = ($urandom_range(0, 99) < 55);
            v1 = $urandom_range(0, 1);
            v2 = $urandom_range(0, 1);
            fd = ($urandom_range(0, 99) < 50);
            sz = m_order.size();
            if (sz > 0 && $urandom_range(0, 3) != 0) fi = m_order[$urandom_range(0, sz - 1)];
            else fi = $urandom_range(0, 15);
            cycle(r, rd, 5'($urandom), 1'($urandom),
                  v1, $urandom_range(0, 15), {$urandom, $urandom},
                  v2, $urandom_range(0, 15), {$urandom, $urandom},
                  fd, fi, {$urandom, $urandom}, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
